// File: rtl/logic_unit_pkg.sv
// Shared types and constants for the logic unit family.
package logic_unit_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NOT  = 3'd2,
    OP_XOR  = 3'd3,
    OP_NAND = 3'd4,
    OP_NOR  = 3'd5,
    OP_XNOR = 3'd6,
    OP_PASS = 3'd7
  } op_e;

endpackage

// File: rtl/logic_unit_pipe_if.sv
// Operand/result stream and counter bundle for logic_unit_pipe.
interface logic_unit_pipe_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) ();
  import logic_unit_pkg::*;

  logic             in_valid;
  logic             in_ready;
  op_e              in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] in_c;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_zero;
  logic             out_parity;
  logic             clr;
  logic [CNT_W-1:0] done_count;

  // Source / consumer side.
  modport master (
    output in_valid, in_op, in_a, in_b, in_c, out_ready, clr,
    input  in_ready, out_valid, out_result, out_zero, out_parity, done_count
  );

  // Pipeline side.
  modport slave (
    input  in_valid, in_op, in_a, in_b, in_c, out_ready, clr,
    output in_ready, out_valid, out_result, out_zero, out_parity, done_count
  );

endinterface

// File: rtl/logic_unit_core.sv
// Combinational bitwise operator with zero and parity flags.
module logic_unit_core
  import logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             parity
);

  // Operation select; NOT is the only op that reads c.
  always_comb begin
    result = '0;
    case (op)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_NOT:  result = ~c;
      OP_XOR:  result = a ^ b;
      OP_NAND: result = ~(a & b);
      OP_NOR:  result = ~(a | b);
      OP_XNOR: result = ~(a ^ b);
      OP_PASS: result = a;
      default: result = '0;
    endcase
  end

  assign zero   = (result == '0);
  assign parity = ^result;

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready bitwise operator pipe with saturating completion counter.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input logic              clk,
  input logic              rst,
  logic_unit_pipe_if.slave bus
);

  logic             s1_valid;
  op_e              s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [WIDTH-1:0] s1_c;

  logic             s2_valid;
  logic [WIDTH-1:0] s2_result;
  logic             s2_zero;
  logic             s2_parity;

  logic [CNT_W-1:0] cnt;

  logic             s1_take;
  logic             s2_take;
  logic             out_hs;

  logic [WIDTH-1:0] core_result;
  logic             core_zero;
  logic             core_parity;

  // Each stage advances when it is empty or its successor is advancing.
  assign s2_take = !s2_valid || bus.out_ready;
  assign s1_take = !s1_valid || s2_take;
  assign out_hs  = s2_valid && bus.out_ready;

  assign bus.in_ready = s1_take;

  logic_unit_core #(.WIDTH(WIDTH)) u_core (
    .op     (s1_op),
    .a      (s1_a),
    .b      (s1_b),
    .c      (s1_c),
    .result (core_result),
    .zero   (core_zero),
    .parity (core_parity)
  );

  // Stage 1: capture operands on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_op    <= OP_AND;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_c     <= '0;
    end else if (s1_take) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_op <= bus.in_op;
        s1_a  <= bus.in_a;
        s1_b  <= bus.in_b;
        s1_c  <= bus.in_c;
      end
    end
  end

  // Stage 2: register result and flags together so they stay consistent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid  <= 1'b0;
      s2_result <= '0;
      s2_zero   <= 1'b1;
      s2_parity <= 1'b0;
    end else if (s2_take) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_result <= core_result;
        s2_zero   <= core_zero;
        s2_parity <= core_parity;
      end
    end
  end

  // Completion counter: clear wins, otherwise saturating increment per handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (bus.clr) begin
      cnt <= '0;
    end else if (out_hs && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign bus.out_valid  = s2_valid;
  assign bus.out_result = s2_result;
  assign bus.out_zero   = s2_zero;
  assign bus.out_parity = s2_parity;
  assign bus.done_count = cnt;

endmodule
